// File: rtl/hidden_cpu_pkg.sv
// Shared types and pin map for the host-side CPU pin driver.
package hidden_cpu_pkg;

    localparam int INSTR_W       = 6;
    localparam int CPU_CLK_BIT   = 0;
    localparam int CPU_RST_BIT   = 1;
    localparam int CPU_INSTR_LSB = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_SETUP,
        S_RST_PULSE,
        S_RST_SAMPLE,
        S_SETUP,
        S_PULSE,
        S_SAMPLE,
        S_DONE
    } state_t;

    function automatic logic [7:0] cpu_pins(input logic [INSTR_W-1:0] instr,
                                            input logic cpu_rst,
                                            input logic cpu_clk);
        logic [7:0] p;
        p = '0;
        p[CPU_INSTR_LSB +: INSTR_W] = instr;
        p[CPU_RST_BIT]              = cpu_rst;
        p[CPU_CLK_BIT]              = cpu_clk;
        return p;
    endfunction

endpackage

// File: rtl/hidden_cpu_host_if.sv
// Host-side control, program-load stream and observation bus of hidden_cpu_host.
interface hidden_cpu_host_if;
    import hidden_cpu_pkg::*;

    logic               load_restart;
    logic               load_valid;
    logic [INSTR_W-1:0] load_data;
    logic               load_ready;
    logic               run;
    logic [7:0]         max_steps;
    logic               busy;
    logic               obs_valid;
    logic [7:0]         obs_data;
    logic [7:0]         step_count;
    logic               done;
    logic               done_halt;

    modport master (
        output load_restart, load_valid, load_data, run, max_steps,
        input  load_ready, busy, obs_valid, obs_data, step_count, done, done_halt
    );

    modport slave (
        input  load_restart, load_valid, load_data, run, max_steps,
        output load_ready, busy, obs_valid, obs_data, step_count, done, done_halt
    );

endinterface

// File: rtl/host_prog_mem.sv
// Program store: flop array with one synchronous write port and one combinational read.
module host_prog_mem
    import hidden_cpu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = INSTR_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array is reset on purpose: a host reset must leave every program word at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hidden_cpu_host.sv
// Loads a program, resets the pin-level CPU, then single-steps it three host clocks per step.
module hidden_cpu_host
    import hidden_cpu_pkg::*;
#(
    parameter int         PROG_DEPTH = 16,
    parameter logic [7:0] HALT_ADDR  = 8'hFF
) (
    input  logic                clk,
    input  logic                rst,
    hidden_cpu_host_if.slave    host,
    output logic [7:0]          cpu_in,
    input  logic [7:0]          cpu_out
);

    localparam int               ADDR_W    = $clog2(PROG_DEPTH);
    localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W+1)'(PROG_DEPTH);

    state_t             state, state_next;
    logic [ADDR_W:0]    load_ptr;
    logic [ADDR_W-1:0]  addr;
    logic [7:0]         budget;
    logic [INSTR_W-1:0] instr;
    logic [7:0]         cpu_in_next;
    logic               load_we;
    logic               halt_hit;
    logic               budget_hit;

    assign host.load_ready = (state == S_IDLE) && (load_ptr < DEPTH_CNT);
    assign load_we         = host.load_valid && host.load_ready && !host.load_restart;
    assign halt_hit        = (host.obs_data == HALT_ADDR);
    assign budget_hit      = (budget != '0) && (host.step_count == budget);

    host_prog_mem #(.DEPTH(PROG_DEPTH), .WIDTH(INSTR_W), .AW(ADDR_W)) u_prog_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (load_we),
        .waddr (load_ptr[ADDR_W-1:0]),
        .wdata (host.load_data),
        .raddr (addr),
        .rdata (instr)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: defaults come first so no path through the case leaves a signal unassigned (no latch).
    always_comb begin
        state_next  = state;
        cpu_in_next = '0;
        case (state)
            S_IDLE:       if (host.run) state_next = S_RST_SETUP;
            S_RST_SETUP:  state_next = S_RST_PULSE;
            S_RST_PULSE:  state_next = S_RST_SAMPLE;
            S_RST_SAMPLE: state_next = S_SETUP;
            S_SETUP:      state_next = S_PULSE;
            S_PULSE:      state_next = S_SAMPLE;
            S_SAMPLE:     state_next = (halt_hit || budget_hit) ? S_DONE : S_SETUP;
            S_DONE:       state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase

        // cpu_in is registered, so the pin value is chosen for the state being entered
        case (state_next)
            S_RST_SETUP: cpu_in_next = cpu_pins('0, 1'b1, 1'b0);
            S_RST_PULSE: cpu_in_next = cpu_pins('0, 1'b1, 1'b1);
            S_SETUP:     cpu_in_next = cpu_pins(instr, 1'b0, 1'b0);
            S_PULSE:     cpu_in_next = cpu_pins(cpu_in[CPU_INSTR_LSB +: INSTR_W], 1'b0, 1'b1);
            S_SAMPLE:    cpu_in_next = cpu_pins(cpu_in[CPU_INSTR_LSB +: INSTR_W], 1'b0, 1'b0);
            default:     cpu_in_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_in          <= '0;
            load_ptr        <= '0;
            addr            <= '0;
            budget          <= '0;
            host.busy       <= 1'b0;
            host.obs_valid  <= 1'b0;
            host.obs_data   <= '0;
            host.step_count <= '0;
            host.done       <= 1'b0;
            host.done_halt  <= 1'b0;
        end else begin
            cpu_in         <= cpu_in_next;
            host.obs_valid <= (state == S_PULSE);
            host.done      <= (state_next == S_DONE);
            host.busy      <= (state_next != S_IDLE) && (state_next != S_DONE);

            if (state == S_IDLE) begin
                if (host.load_restart) load_ptr <= '0;
                else if (load_we)      load_ptr <= load_ptr + (ADDR_W+1)'(1);
            end

            if (state == S_IDLE && host.run) begin
                budget          <= host.max_steps;
                host.step_count <= '0;
                host.done_halt  <= 1'b0;
            end

            // cpu_out is taken one host clock after the CPU clock rise
            if (state == S_RST_PULSE || state == S_PULSE) addr <= cpu_out[ADDR_W-1:0];

            if (state == S_PULSE) begin
                host.obs_data <= cpu_out;
                if (host.step_count != 8'hFF) host.step_count <= host.step_count + 8'd1;
            end

            if (state == S_SAMPLE && halt_hit) host.done_halt <= 1'b1;
        end
    end

endmodule
